// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - pending register write-back queue with in-order drain and read bypass
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid,
  input  logic [3:0]             wb_reg,
  input  logic [15:0]            wb_data,
  output logic                   wb_ready,
  input  logic                   hold,
  output logic [15:0]            reg_wr_en,
  output logic [15:0]            reg_wr_data,
  input  logic [3:0]             rd_reg1,
  input  logic [3:0]             rd_reg2,
  output logic                   byp_hit1,
  output logic                   byp_hit2,
  output logic [15:0]            byp_data1,
  output logic [15:0]            byp_data2,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    r_reg  [DEPTH];
  logic [15:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_enq;
  logic          w_drain;
  logic [16:0]   w_lk1;
  logic [16:0]   w_lk2;

  // Scan oldest to youngest so the last match (youngest) wins.
  function automatic logic [16:0] lookup(input logic [3:0] rd);
    logic [16:0]   res;
    logic [AW-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + AW'(i);
      if ((CW'(i) < r_count) && (rd != 4'd0) && (r_reg[idx] == rd))
        res = {1'b1, r_data[idx]};
    end
    return res;
  endfunction

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign wb_ready = !w_full;
  assign w_enq    = wb_valid && !w_full && (wb_reg != 4'd0);
  assign w_drain  = !w_empty && !hold;

  assign reg_wr_en   = w_drain ? (16'd1 << r_reg[r_head]) : 16'd0;
  assign reg_wr_data = w_empty ? 16'd0 : r_data[r_head];

  assign w_lk1     = lookup(rd_reg1);
  assign w_lk2     = lookup(rd_reg2);
  assign byp_hit1  = w_lk1[16];
  assign byp_data1 = w_lk1[15:0];
  assign byp_hit2  = w_lk2[16];
  assign byp_data2 = w_lk2[15:0];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_reg[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_reg[r_tail]  <= wb_reg;
        r_data[r_tail] <= wb_data;
        r_tail         <= r_tail + AW'(1);
      end
      if (w_drain)
        r_head <= r_head + AW'(1);
      if (w_enq && !w_drain)
        r_count <= r_count + CW'(1);
      else if (!w_enq && w_drain)
        r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - directed self-checking bench for wb_queue
module tb_wb_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        wb_ready;
  logic        hold;
  logic [15:0] reg_wr_en;
  logic [15:0] reg_wr_data;
  logic [3:0]  rd_reg1;
  logic [3:0]  rd_reg2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [15:0] byp_data1;
  logic [15:0] byp_data2;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  logic [19:0] mq[$];
  logic [19:0] e;
  logic [15:0] one_hot;

  wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_ready(wb_ready), .hold(hold), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; wb_valid = 1'b1; wb_reg = 4'd7; wb_data = 16'h7777;
    hold = 1'b0; rd_reg1 = 4'd3; rd_reg2 = 4'd7;
    tick(); tick();
    rst = 1'b1; wb_valid = 1'b0; #1;
    check("rst_count", count, 0);
    check("rst_ready", wb_ready, 1);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_wr_data", reg_wr_data, 0);
    check("rst_hit1", byp_hit1, 0);
    check("rst_hit2", byp_hit2, 0);
    check("rst_data1", byp_data1, 0);

    // single write R3
    wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 16'hBEEF; #1;
    check("r3_pre_wr_en", reg_wr_en, 0);
    check("r3_no_fwd", byp_hit1, 0);
    tick();
    wb_valid = 1'b0; #1;
    check("r3_wr_en", reg_wr_en, 16'h0008);
    check("r3_wr_data", reg_wr_data, 16'hBEEF);
    check("r3_count1", count, 1);
    check("r3_hit1", byp_hit1, 1);
    check("r3_data1", byp_data1, 16'hBEEF);
    tick();
    check("r3_count0", count, 0);
    check("r3_wr_en_off", reg_wr_en, 0);

    // fill under hold, reject when full, drain in order
    hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wb_valid = 1'b1; wb_reg = 4'(k); wb_data = 16'(k); #1;
      check("fill_ready", wb_ready, 1);
      tick();
    end
    check("full_count", count, 4);
    check("full_ready", wb_ready, 0);
    wb_reg = 4'd5; wb_data = 16'h0005;
    tick();
    check("full_reject_count", count, 4);
    check("hold_wr_en", reg_wr_en, 0);
    check("hold_wr_data", reg_wr_data, 16'h0001);
    hold = 1'b0; wb_reg = 4'd6; wb_data = 16'h0006; #1;
    check("full_drain_ready", wb_ready, 0);
    check("drain0_wr_en", reg_wr_en, 16'h0002);
    check("drain0_wr_data", reg_wr_data, 16'h0001);
    tick();
    wb_valid = 1'b0; #1;
    check("no_slot_reuse", count, 3);
    for (int k = 2; k <= 4; k++) begin
      one_hot = 16'd1 << k;
      check("drain_wr_en", reg_wr_en, one_hot);
      check("drain_wr_data", reg_wr_data, 16'(k));
      tick();
    end
    check("drain_count0", count, 0);
    check("drain_idle", reg_wr_en, 0);

    // bypass: youngest match wins, in-flight offer not forwarded
    hold = 1'b1;
    wb_valid = 1'b1; wb_reg = 4'd5; wb_data = 16'h1111; tick();
    wb_data = 16'h2222; tick();
    wb_reg = 4'd6; wb_data = 16'hABCD; rd_reg1 = 4'd5; rd_reg2 = 4'd6; #1;
    check("byp_hit1", byp_hit1, 1);
    check("byp_data1_young", byp_data1, 16'h2222);
    check("byp_inflight_hit2", byp_hit2, 0);
    check("byp_inflight_data2", byp_data2, 0);
    tick();
    wb_valid = 1'b0; #1;
    check("byp_hit2_stored", byp_hit2, 1);
    check("byp_data2_stored", byp_data2, 16'hABCD);
    check("byp_count3", count, 3);

    // reset with 3 entries pending, plus competing offer and drain
    hold = 1'b0; rst = 1'b0; wb_valid = 1'b1; wb_reg = 4'd9; wb_data = 16'h9999;
    tick();
    rst = 1'b1; wb_valid = 1'b0; #1;
    check("mrst_count", count, 0);
    check("mrst_wr_en", reg_wr_en, 0);
    check("mrst_hit1", byp_hit1, 0);
    check("mrst_hit2", byp_hit2, 0);
    check("mrst_data1", byp_data1, 0);
    tick();
    check("mrst_wr_en2", reg_wr_en, 0);

    // R0 writes are discarded
    wb_valid = 1'b1; wb_reg = 4'd0; wb_data = 16'hFFFF; rd_reg1 = 4'd0; #1;
    check("r0_ready", wb_ready, 1);
    tick();
    wb_valid = 1'b0; #1;
    check("r0_count", count, 0);
    check("r0_wr_en", reg_wr_en, 0);
    check("r0_hit1", byp_hit1, 0);

    // steady state enqueue+drain with pointer wrap
    hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wb_valid = 1'b1; wb_reg = 4'(k + 1); wb_data = 16'h0100 + 16'(k);
      mq.push_back({wb_reg, wb_data});
      tick();
    end
    check("ss_prefill", count, 2);
    hold = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wb_valid = 1'b1; wb_reg = 4'((k % 15) + 1); wb_data = 16'h0200 + 16'(k); #1;
      e = mq.pop_front();
      one_hot = 16'd1 << e[19:16];
      check("ss_wr_en", reg_wr_en, one_hot);
      check("ss_wr_data", reg_wr_data, e[15:0]);
      mq.push_back({wb_reg, wb_data});
      tick();
      check("ss_count", count, 2);
    end
    wb_valid = 1'b0;
    while (mq.size() > 0) begin
      #1;
      e = mq.pop_front();
      one_hot = 16'd1 << e[19:16];
      check("ss_tail_wr_en", reg_wr_en, one_hot);
      check("ss_tail_wr_data", reg_wr_data, e[15:0]);
      tick();
    end
    check("ss_empty", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter: DEPTH, default 4, number of pending-write entries (power of two, min 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 SHALL have port: wb_valid  input  1  producer offers a register write this cycle.
REQ-005 SHALL have port: wb_reg  input  4  destination register index.
REQ-006 SHALL have port: wb_data  input  16  value to write.
REQ-007 SHALL have port: wb_ready  output  1  queue can accept an offer this cycle.
REQ-008 SHALL have port: hold  input  1  register file not writable this cycle; suppresses drain.
REQ-009 SHALL have port: reg_wr_en  output  16  one-hot per-register write enables to register file.
REQ-010 SHALL have port: reg_wr_data  output  16  data driven onto register file write data bus.
REQ-011 SHALL have port: rd_reg1, rd_reg2  input  4 each  register indices being read this cycle.
REQ-012 SHALL have port: byp_hit1, byp_hit2  output  1 each  a pending write targets rd_reg1/rd_reg2.
REQ-013 SHALL have port: byp_data1, byp_data2  output  16 each  forwarded value for rd_reg1/rd_reg2.
REQ-014 SHALL have port: count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL store pending writes in a circular FIFO of DEPTH entries {reg[3:0], data[15:0]} with head/tail pointers wrapping modulo DEPTH.
REQ-016 SHALL assert wb_ready iff count < DEPTH; wb_ready depends only on registered state, never on wb_valid or hold.
REQ-017 SHALL accept (enqueue at tail) on a rising edge where wb_valid && wb_ready && wb_reg != 0.
REQ-018 SHALL silently discard offers with wb_reg == 0 (R0 hardwired zero): handshake completes, no entry, count unchanged.
REQ-019 SHALL, when count > 0 and hold == 0, drive reg_wr_en = one-hot(head.reg) and reg_wr_data = head.data combinationally, and pop head on that rising edge.
REQ-020 SHALL drive reg_wr_en = 16'h0000 when count == 0 or hold == 1; reg_wr_data = head.data when count > 0, else 16'h0000.
REQ-021 SHALL give latency 1: offer accepted at edge N into empty queue appears on reg_wr_en during cycle N+1 (if hold low).
REQ-022 SHALL support simultaneous enqueue and drain in one cycle: count unchanged, both pointers advance.
REQ-023 SHALL, on enqueue with no drain, increment count; on drain with no enqueue, decrement count; count never exceeds DEPTH nor underflows.
REQ-024 SHALL, when full, deassert wb_ready even if a drain occurs the same cycle (no same-cycle slot reuse).
REQ-025 SHALL compute byp_hitN = 1 iff any valid entry (including head being drained) has reg == rd_regN and rd_regN != 0.
REQ-026 SHALL drive byp_dataN from the youngest (closest to tail) matching entry; 16'h0000 when byp_hitN == 0.
REQ-027 SHALL NOT forward the in-flight wb_data offer; only stored entries are searched.
REQ-028 SHALL preserve program order: entries drain strictly in acceptance order, including repeated writes to same register.
REQ-029 SHALL keep hold from affecting acceptance; hold only freezes the head.

Reset
REQ-030 SHALL, on rising edge with rst == 0, set head = tail = 0, count = 0, clear all entry contents to 0.
REQ-031 SHALL, during and one cycle after reset, output wb_ready = 1 (count 0), reg_wr_en = 0, reg_wr_data = 0, byp_hit1/2 = 0, byp_data1/2 = 0.
REQ-032 SHALL give reset priority over simultaneous enqueue/drain: pending entries discarded, no reg_wr_en pulse after the reset edge.
REQ-033 SHALL ignore wb_valid on edges where rst == 0.

Verification
REQ-034 SHALL pass: reset, then offer R3=16'hBEEF, hold=0 -> next cycle reg_wr_en=16'h0008, reg_wr_data=16'hBEEF, count returns to 0 after that edge.
REQ-035 SHALL pass: hold=1, offer R1..R4 with 16'h0001..16'h0004 on consecutive cycles -> count=4, wb_ready=0, fifth offer not accepted; release hold -> enables 16'h0002,16'h0004,16'h0008,16'h0010 in order.
REQ-036 SHALL pass: hold=1, enqueue R5=16'h1111 then R5=16'h2222, rd_reg1=5 -> byp_hit1=1, byp_data1=16'h2222; rd_reg2=6 -> byp_hit2=0, byp_data2=0.
REQ-037 SHALL pass: offer R0=16'hFFFF -> wb_ready=1, count stays 0, no reg_wr_en pulse; rd_reg1=0 -> byp_hit1=0.
REQ-038 SHALL pass: count=2, simultaneous valid offer and drain -> count stays 2; with DEPTH=4, 10 such cycles exercise pointer wrap with in-order data.
REQ-039 SHALL pass: queue holding 3 entries, rst=0 for one edge -> count=0, reg_wr_en=0 thereafter, byp_hit1/2=0.
